// File: rtl/cpu_txn_gen.sv
// cpu_txn_gen -- CPU read/write transaction generator that drives the cache
// controller. It replays entries from a run-time-writable pattern table. A
// transaction starts on each rising edge of trig_i (step mode) or
// back-to-back (run mode). cs_o is held until rdy_i arrives, with a minimum
// length of CS_CYCLES. An optional TIMEOUT aborts a transaction and sets a
// sticky error flag.
//
// Ports:
//   clk_i        system clock; all logic is on the rising edge
//   rst_i        synchronous active-high reset
//   trig_i       step trigger (raw level, e.g. a push-button)
//   run_i        1 = free-run mode, 0 = step mode
//   rdy_i        transaction-complete strobe from the cache controller
//   pat_we_i     pattern table write enable
//   pat_waddr_i  pattern table write index
//   pat_wdata_i  pattern table entry {addr, data, wr_rd}; wr_rd=1 is a write
//   Address_o    transaction address
//   DOut_o       write data
//   wr_rd_o      1 = write, 0 = read
//   cs_o         transaction strobe
//   busy_o       high whenever the FSM is not IDLE
//   txn_cnt_o    completed-transaction count (wraps at 2^16)
//   err_o        sticky timeout flag
module cpu_txn_gen #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int CS_CYCLES = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       trig_i,
   input  logic                       run_i,
   input  logic                       rdy_i,
   input  logic                       pat_we_i,
   input  logic [$clog2(DEPTH)-1:0]   pat_waddr_i,
   input  logic [ADDR_W+DATA_W:0]     pat_wdata_i,
   output logic [ADDR_W-1:0]          Address_o,
   output logic [DATA_W-1:0]          DOut_o,
   output logic                       wr_rd_o,
   output logic                       cs_o,
   output logic                       busy_o,
   output logic [15:0]                txn_cnt_o,
   output logic                       err_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENT_W   = ADDR_W + DATA_W + 1;
   localparam int CYC_MAX = (TIMEOUT > CS_CYCLES) ? TIMEOUT : CS_CYCLES;
   // One spare bit so the saturating counter never aliases onto CYC_MAX.
   localparam int CYC_W   = $clog2(CYC_MAX + 1) + 1;

   localparam logic [CYC_W-1:0] CS_MIN  = CYC_W'(CS_CYCLES);
   localparam logic [CYC_W-1:0] TO_LIM  = CYC_W'(TIMEOUT);
   localparam bit               TO_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    ptr_d;
   logic [CYC_W-1:0]    cyc_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   dout_q;
   logic                wr_rd_q;
   logic [15:0]         txn_cnt_q;
   logic                err_q;
   logic                trig_r1_q;
   logic                trig_r2_q;
   logic                trig_rise;
   logic [ENT_W-1:0]    tbl_q [DEPTH];

   // DEPTH is a power of two, so the increment wraps DEPTH-1 -> 0 by itself.
   assign ptr_d     = ptr_q + 1'b1;
   assign trig_rise = trig_r1_q & ~trig_r2_q;

   // Pattern table. A write landing in the same cycle as a LOAD read of the
   // same entry is seen only by later transactions.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= '0;
         end
      end else if (pat_we_i) begin
         tbl_q[pat_waddr_i] <= pat_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_W'(DEPTH - 1);
         cyc_q     <= '0;
         addr_q    <= '0;
         dout_q    <= '0;
         wr_rd_q   <= 1'b0;
         txn_cnt_q <= '0;
         err_q     <= 1'b0;
         trig_r1_q <= 1'b0;
         trig_r2_q <= 1'b0;
      end else begin
         trig_r1_q <= trig_i;
         trig_r2_q <= trig_r1_q;
         case (state_q)
            IDLE: begin
               // A trigger edge seen outside IDLE is dropped, not queued.
               if (run_i || trig_rise) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               ptr_q                      <= ptr_d;
               {addr_q, dout_q, wr_rd_q}  <= tbl_q[ptr_d];
               cyc_q                      <= CYC_W'(1);
               state_q                    <= ACTIVE;
            end
            ACTIVE: begin
               // Saturate so an unbounded wait (TIMEOUT=0) cannot wrap back
               // below CS_CYCLES.
               if (cyc_q != '1) begin
                  cyc_q <= cyc_q + 1'b1;
               end
               if (cyc_q >= CS_MIN && rdy_i) begin
                  txn_cnt_q <= txn_cnt_q + 16'd1;
                  state_q   <= IDLE;
               end else if (TO_EN && cyc_q == TO_LIM && !rdy_i) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Address_o = addr_q;
   assign DOut_o    = dout_q;
   assign wr_rd_o   = wr_rd_q;
   assign cs_o      = (state_q == ACTIVE);
   assign busy_o    = (state_q != IDLE);
   assign txn_cnt_o = txn_cnt_q;
   assign err_o     = err_q;

endmodule

// File: doc/cpu_txn_gen.md
Name: cpu_txn_gen

Overview:
Parametrised CPU read/write transaction generator that acts as the stimulus master for the cache controller. It replays entries from a run-time-writable pattern table. Each transaction is started by a rising trigger edge (step mode) or back-to-back (run mode). Unlike the fixed-length generator, it holds cs until the controller signals rdy, enforces a minimum cs length, counts completed transactions and flags timeouts.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, write-data width
DEPTH, 8, pattern table entries (power of 2, >=2)
CS_CYCLES, 4, minimum cycles cs is held high per transaction (>=1)
TIMEOUT, 64, max cs-high cycles before abort (0 = no timeout; otherwise >=CS_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
trig  in  1  step trigger (asynchronous level, e.g. push-button)
run  in  1  1 = free-run mode, 0 = step mode
rdy  in  1  transaction-complete strobe from cache controller
pat_we  in  1  pattern table write enable
pat_waddr  in  log2(DEPTH)  table write index
pat_wdata  in  ADDR_W+DATA_W+1  entry {addr, data, wr_rd}; wr_rd=1 is write
Address  out  ADDR_W  transaction address
DOut  out  DATA_W  write data
wr_rd  out  1  1 = write, 0 = read
cs  out  1  transaction strobe
busy  out  1  high when state != IDLE
txn_cnt  out  16  completed-transaction count
err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous): state=IDLE; ptr=DEPTH-1; all table entries=0; Address, DOut, wr_rd, cs, txn_cnt, err=0; edge-detector flops=0.
- Trigger detection: two flops r1<=trig, r2<=r1; trig_r = r1 & ~r2. trig is not otherwise synchronised.
- FSM states are IDLE, LOAD and ACTIVE.
- IDLE: go to LOAD if (run=1) or (run=0 and trig_r=1). trig_r is ignored in every other state and is not queued.
- LOAD (1 cycle): ptr <= ptr+1, wrapping DEPTH-1 -> 0. Address/DOut/wr_rd <= table[ptr+1]. cyc <= 1. Next state is ACTIVE. The first transaction after reset uses entry 0.
- ACTIVE: cs=1 (decoded from registered state). cyc increments each cycle.
  - If cyc>=CS_CYCLES and rdy=1: txn_cnt++ (wraps at 2^16), next state IDLE.
  - Else if TIMEOUT!=0, cyc==TIMEOUT and rdy=0: err<=1, next state IDLE, txn_cnt unchanged.
  - rdy while cyc<CS_CYCLES is ignored.
- Latency in step mode: trig high sampled at edge k; LOAD from edge k+1; outputs valid and cs=1 from edge k+2. With rdy tied high, cs is high for exactly CS_CYCLES cycles.
- Gap: cs is low for at least 2 cycles (IDLE + LOAD) between transactions, including in run mode.
- Outputs: Address/DOut/wr_rd hold their value after a transaction until the next LOAD. They are latched, so a pat_we to the active entry during ACTIVE does not change the current outputs.
- Table write: pat_we accepted in any state. A write and a LOAD read of the same entry in the same cycle: LOAD gets the old contents.
- run deasserted during ACTIVE: the current transaction completes, then the block waits in IDLE for trig.
- rst in ACTIVE: next cycle cs=0, state IDLE, no count increment.

Test Plan:
- Reset defaults, rdy tied 1, run=0, CS_CYCLES=4: one trig pulse -> cs high exactly 4 cycles starting 2 cycles after first trig sample. Address=0x0000, DOut=0x00, wr_rd=0, txn_cnt=1.
- Load table entry0={0x1100,0xAA,1} and entry1={0x1101,0x5B,1}, two triggers -> first cs with Address=0x1100/DOut=0xAA/wr_rd=1, second with 0x1101/0x5B/1. txn_cnt=2.
- Wrap: DEPTH=8, 9 triggers -> the 9th transaction reuses entry 0 values. txn_cnt=9.
- Handshake: rdy first asserted 10 cycles after cs rises -> cs high 10 cycles. Then rdy held high from cs rise -> cs high 4 cycles. Trig pulses during ACTIVE produce no extra transaction.
- Timeout: TIMEOUT=64, rdy held 0 -> cs high 64 cycles then low, err=1 and stays 1 through later good transactions until rst. txn_cnt unchanged.
- Run mode, rdy=1: cs pattern is 4 high / 2 low repeating. Assert rst mid-ACTIVE -> cs=0 on the next edge, then txn_cnt=0, err=0, ptr restarts at entry 0.
